// File: rtl/stream_mac_cell_pkg.sv
// -----------------------------------------------------------------------------
// cell_package
// Shared definitions for the stream MAC cell family:
//   DATA_WIDTH / WINDEX_WIDTH : beat payload and weight-index widths
//   cellstruct                : one beat on the cell stream
//   activation_t              : output activation selector
//   saturate()                : clamp a wide signed value into DATA_WIDTH
// -----------------------------------------------------------------------------
package cell_package;

    localparam int DATA_WIDTH   = 8;
    localparam int WINDEX_WIDTH = 8;

    // Width of the operand accepted by saturate(); wide enough for any
    // accumulator this cell family builds.
    localparam int SAT_IN_WIDTH = 64;

    typedef struct packed {
        logic signed [DATA_WIDTH-1:0]   data;
        logic                           isValid;
        logic                           isFirst;
        logic                           isLast;
        logic                           isResult;
        logic        [WINDEX_WIDTH-1:0] wIndex;
    } cellstruct;

    typedef enum logic [0:0] {
        ACT_NONE = 1'b0,
        ACT_RELU = 1'b1
    } activation_t;

    // Clamp to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
    function automatic logic signed [DATA_WIDTH-1:0] saturate(
        input logic signed [SAT_IN_WIDTH-1:0] value
    );
        logic signed [SAT_IN_WIDTH-1:0] max_v;
        logic signed [SAT_IN_WIDTH-1:0] min_v;
        max_v = (64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (value > max_v) begin
            return max_v[DATA_WIDTH-1:0];
        end else if (value < min_v) begin
            return min_v[DATA_WIDTH-1:0];
        end else begin
            return value[DATA_WIDTH-1:0];
        end
    endfunction

endpackage

// File: rtl/stream_mac_cell_result_fifo.sv
// -----------------------------------------------------------------------------
// result_fifo
// Synchronous circular-buffer FIFO holding finished cell results.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   push, din    : write request and data (ignored when full unless popping)
//   pop, dout    : read request and current head (valid when !empty)
//   full, empty  : occupancy flags
//   count        : registered occupancy, 0..DEPTH
// Push and pop in the same cycle are accepted even when full.
// -----------------------------------------------------------------------------
module result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_WIDTH = $clog2(DEPTH + 1);
    localparam logic [PTR_WIDTH-1:0] LAST_SLOT  = PTR_WIDTH'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(DEPTH);

    logic [WIDTH-1:0]     mem_r [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr_r;
    logic [PTR_WIDTH-1:0] rd_ptr_r;
    logic [CNT_WIDTH-1:0] count_r;
    logic                 full_s;
    logic                 empty_s;
    logic                 do_push_s;
    logic                 do_pop_s;

    // Advance a pointer with wrap at DEPTH (DEPTH need not be a power of two).
    function automatic logic [PTR_WIDTH-1:0] bump(input logic [PTR_WIDTH-1:0] ptr);
        return (ptr == LAST_SLOT) ? {PTR_WIDTH{1'b0}} : ptr + PTR_WIDTH'(1);
    endfunction

    // Flags and accepted operations; a pop frees the slot a full push needs.
    always_comb begin
        full_s    = (count_r == FULL_COUNT);
        empty_s   = (count_r == {CNT_WIDTH{1'b0}});
        do_pop_s  = pop & ~empty_s;
        do_push_s = push & (~full_s | do_pop_s);
    end

    // Storage array.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Read/write pointers and occupancy counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= {PTR_WIDTH{1'b0}};
            rd_ptr_r <= {PTR_WIDTH{1'b0}};
            count_r  <= {CNT_WIDTH{1'b0}};
        end else begin
            wr_ptr_r <= do_push_s ? bump(wr_ptr_r) : wr_ptr_r;
            rd_ptr_r <= do_pop_s  ? bump(rd_ptr_r) : rd_ptr_r;
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_WIDTH'(1);
                2'b01:   count_r <= count_r - CNT_WIDTH'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign full  = full_s;
    assign empty = empty_s;
    assign count = count_r;

endmodule

// File: rtl/stream_mac_cell.sv
// -----------------------------------------------------------------------------
// stream_mac_cell
// Accumulates a weighted dot product over framed vectors on the cell stream,
// forwards every input beat one cycle later, and injects each finished result
// (shifted, saturated, optionally ReLU'd) into the first idle stream slot.
// Ports:
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   streamIn       : upstream beat
//   streamOut      : registered downstream beat (pass-through or result)
//   weightWrEn     : weight write strobe
//   weightWrIndex  : weight slot to write (out-of-range ignored)
//   weightWrData   : signed weight value
//   overflow       : sticky, set when a result is dropped on a full FIFO
//   pendingCount   : results waiting for an idle slot
// -----------------------------------------------------------------------------
module stream_mac_cell
    import cell_package::*;
#(
    parameter int          INPUT_VECTOR_SIZE = 3,
    parameter logic [INPUT_VECTOR_SIZE-1:0][DATA_WIDTH-1:0] WEIGHTS_INIT = '0,
    parameter int          CELL_ID           = 0,
    parameter activation_t ACTIVATION        = ACT_NONE,
    parameter int          OUT_SHIFT         = 0,
    parameter int          RESULT_FIFO_DEPTH = 4
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  cellstruct                              streamIn,
    output cellstruct                              streamOut,
    input  logic                                   weightWrEn,
    input  logic        [WINDEX_WIDTH-1:0]         weightWrIndex,
    input  logic signed [DATA_WIDTH-1:0]           weightWrData,
    output logic                                   overflow,
    output logic [$clog2(RESULT_FIFO_DEPTH+1)-1:0] pendingCount
);

    // Extra clog2 + 1 bits keep a full vector of extreme products from wrapping.
    localparam int ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(INPUT_VECTOR_SIZE) + 1;
    localparam int PROD_WIDTH = 2 * DATA_WIDTH;
    localparam int CNT_WIDTH  = $clog2(RESULT_FIFO_DEPTH + 1);
    localparam logic [WINDEX_WIDTH:0]   VEC_SIZE   = (WINDEX_WIDTH + 1)'(INPUT_VECTOR_SIZE);
    localparam logic [WINDEX_WIDTH-1:0] RESULT_TAG = WINDEX_WIDTH'(CELL_ID);

    logic signed [DATA_WIDTH-1:0] weights_r [INPUT_VECTOR_SIZE];
    logic signed [ACC_WIDTH-1:0]  acc_r;
    cellstruct                    stream_out_r;
    logic                         overflow_r;

    logic                         index_ok_s;
    logic signed [DATA_WIDTH-1:0] weight_sel_s;
    logic signed [PROD_WIDTH-1:0] product_s;
    logic signed [ACC_WIDTH-1:0]  product_ext_s;
    logic signed [ACC_WIDTH-1:0]  sum_s;
    logic signed [ACC_WIDTH-1:0]  shifted_s;
    logic signed [DATA_WIDTH-1:0] saturated_s;
    logic signed [DATA_WIDTH-1:0] result_s;
    logic                         accumulate_s;
    logic                         push_s;
    logic                         pop_s;
    logic [DATA_WIDTH-1:0]        fifo_head_s;
    logic                         fifo_full_s;
    logic                         fifo_empty_s;
    logic [CNT_WIDTH-1:0]         fifo_count_s;
    cellstruct                    injected_s;

    // Weight lookup and product; an out-of-range index contributes zero.
    always_comb begin
        index_ok_s   = ({1'b0, streamIn.wIndex} < VEC_SIZE);
        weight_sel_s = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < INPUT_VECTOR_SIZE; i++) begin
            weight_sel_s = (streamIn.wIndex == WINDEX_WIDTH'(i)) ? weights_r[i] : weight_sel_s;
        end
        if (index_ok_s) begin
            product_s = PROD_WIDTH'($signed(streamIn.data)) * PROD_WIDTH'(weight_sel_s);
        end else begin
            product_s = {PROD_WIDTH{1'b0}};
        end
    end

    // Running sum, output conditioning and FIFO handshake.
    always_comb begin
        accumulate_s  = streamIn.isValid & ~streamIn.isResult;
        product_ext_s = ACC_WIDTH'(product_s);
        if (streamIn.isFirst) begin
            sum_s = product_ext_s;
        end else begin
            sum_s = acc_r + product_ext_s;
        end
        shifted_s   = sum_s >>> OUT_SHIFT;
        saturated_s = saturate(SAT_IN_WIDTH'(shifted_s));
        if ((ACTIVATION == ACT_RELU) && saturated_s[DATA_WIDTH-1]) begin
            result_s = {DATA_WIDTH{1'b0}};
        end else begin
            result_s = saturated_s;
        end
        push_s = accumulate_s & streamIn.isLast;
        // Injection only uses idle slots, so push and pop never coincide here.
        pop_s  = ~streamIn.isValid & ~fifo_empty_s;
    end

    // Beat presented when a pending result is injected.
    always_comb begin
        injected_s          = '0;
        injected_s.data     = fifo_head_s;
        injected_s.isValid  = 1'b1;
        injected_s.isFirst  = 1'b0;
        injected_s.isLast   = 1'b0;
        injected_s.isResult = 1'b1;
        injected_s.wIndex   = RESULT_TAG;
    end

    // Weight table: reload on reset, runtime write otherwise.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < INPUT_VECTOR_SIZE; i++) begin
                weights_r[i] <= WEIGHTS_INIT[i];
            end
        end else begin
            for (int i = 0; i < INPUT_VECTOR_SIZE; i++) begin
                if (weightWrEn && (weightWrIndex == WINDEX_WIDTH'(i))) begin
                    weights_r[i] <= weightWrData;
                end else begin
                    weights_r[i] <= weights_r[i];
                end
            end
        end
    end

    // Accumulator: isFirst restarts the sum, other data beats add to it.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_r <= {ACC_WIDTH{1'b0}};
        end else if (accumulate_s) begin
            acc_r <= sum_s;
        end else begin
            acc_r <= acc_r;
        end
    end

    // Sticky overflow when a result finds no room.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_r <= 1'b0;
        end else if (push_s && fifo_full_s && !pop_s) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // Output slot: upstream beats have priority, idle slots carry results.
    always_ff @(posedge clock) begin
        if (reset) begin
            stream_out_r <= '0;
        end else if (streamIn.isValid) begin
            stream_out_r <= streamIn;
        end else if (!fifo_empty_s) begin
            stream_out_r <= injected_s;
        end else begin
            stream_out_r <= '0;
        end
    end

    result_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RESULT_FIFO_DEPTH)
    ) u_result_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .din   (result_s),
        .dout  (fifo_head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    assign streamOut    = stream_out_r;
    assign overflow     = overflow_r;
    assign pendingCount = fifo_count_s;

endmodule

// File: tb/tb_stream_mac_cell.sv
// -----------------------------------------------------------------------------
// tb_stream_mac_cell
// Directed bench: a three-cell chain (head cell also used for framing, weight
// and reset scenarios), saturation/ReLU cells, a depth-2 overflow cell and a
// standalone result_fifo, all fed from one shared stimulus beat.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_stream_mac_cell;
    import cell_package::*;

    logic clock = 1'b0;
    logic reset;
    cellstruct stim;
    logic weightWrEn;
    logic [WINDEX_WIDTH-1:0] weightWrIndex;
    logic signed [DATA_WIDTH-1:0] weightWrData;

    cellstruct c0_out, c1_out, c2_out, s127_out, sn_out, sr_out, ov_out;
    logic c0_ovf, c1_ovf, c2_ovf, s127_ovf, sn_ovf, sr_ovf, ov_ovf;
    logic [2:0] c0_cnt, c1_cnt, c2_cnt, s127_cnt, sn_cnt, sr_cnt;
    logic [1:0] ov_cnt;

    logic f_push, f_pop, f_full, f_empty;
    logic [7:0] f_din, f_dout;
    logic [1:0] f_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    stream_mac_cell #(.WEIGHTS_INIT({8'd2, 8'd1, 8'd0}), .CELL_ID(0)) u_c0 (
        .clock(clock), .reset(reset), .streamIn(stim), .streamOut(c0_out),
        .weightWrEn(weightWrEn), .weightWrIndex(weightWrIndex), .weightWrData(weightWrData),
        .overflow(c0_ovf), .pendingCount(c0_cnt));
    stream_mac_cell #(.WEIGHTS_INIT({8'd3, 8'd2, 8'd1}), .CELL_ID(1)) u_c1 (
        .clock(clock), .reset(reset), .streamIn(c0_out), .streamOut(c1_out),
        .weightWrEn(weightWrEn), .weightWrIndex(weightWrIndex), .weightWrData(weightWrData),
        .overflow(c1_ovf), .pendingCount(c1_cnt));
    stream_mac_cell #(.WEIGHTS_INIT({8'd4, 8'd3, 8'd2}), .CELL_ID(2)) u_c2 (
        .clock(clock), .reset(reset), .streamIn(c1_out), .streamOut(c2_out),
        .weightWrEn(weightWrEn), .weightWrIndex(weightWrIndex), .weightWrData(weightWrData),
        .overflow(c2_ovf), .pendingCount(c2_cnt));
    stream_mac_cell #(.WEIGHTS_INIT({8'd127, 8'd127, 8'd127}), .CELL_ID(3)) u_s127 (
        .clock(clock), .reset(reset), .streamIn(stim), .streamOut(s127_out),
        .weightWrEn(weightWrEn), .weightWrIndex(weightWrIndex), .weightWrData(weightWrData),
        .overflow(s127_ovf), .pendingCount(s127_cnt));
    stream_mac_cell #(.WEIGHTS_INIT({8'hFF, 8'hFF, 8'hFF}), .CELL_ID(4)) u_sn (
        .clock(clock), .reset(reset), .streamIn(stim), .streamOut(sn_out),
        .weightWrEn(weightWrEn), .weightWrIndex(weightWrIndex), .weightWrData(weightWrData),
        .overflow(sn_ovf), .pendingCount(sn_cnt));
    stream_mac_cell #(.WEIGHTS_INIT({8'hFF, 8'hFF, 8'hFF}), .CELL_ID(5), .ACTIVATION(ACT_RELU)) u_sr (
        .clock(clock), .reset(reset), .streamIn(stim), .streamOut(sr_out),
        .weightWrEn(weightWrEn), .weightWrIndex(weightWrIndex), .weightWrData(weightWrData),
        .overflow(sr_ovf), .pendingCount(sr_cnt));
    stream_mac_cell #(.WEIGHTS_INIT({8'd2, 8'd1, 8'd0}), .CELL_ID(6), .RESULT_FIFO_DEPTH(2)) u_ov (
        .clock(clock), .reset(reset), .streamIn(stim), .streamOut(ov_out),
        .weightWrEn(weightWrEn), .weightWrIndex(weightWrIndex), .weightWrData(weightWrData),
        .overflow(ov_ovf), .pendingCount(ov_cnt));

    result_fifo #(.WIDTH(8), .DEPTH(2)) u_fifo (
        .clock(clock), .reset(reset), .push(f_push), .pop(f_pop), .din(f_din),
        .dout(f_dout), .full(f_full), .empty(f_empty), .count(f_count));

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; stim = '0; weightWrEn = 1'b0; weightWrIndex = '0; weightWrData = '0;
        f_push = 1'b0; f_pop = 1'b0; f_din = 8'd0;
        tick(); tick();
        reset = 1'b0;
    endtask

    function automatic cellstruct beat(input int d, input int idx, input bit f, input bit l);
        cellstruct c;
        c = '0; c.data = 8'(d); c.isValid = 1'b1; c.isFirst = f; c.isLast = l; c.wIndex = 8'(idx);
        return c;
    endfunction

    function automatic cellstruct res(input int d, input int id);
        cellstruct c;
        c = '0; c.data = 8'(d); c.isValid = 1'b1; c.isResult = 1'b1; c.wIndex = 8'(id);
        return c;
    endfunction

    task automatic send_vec(input int a, input int b, input int c);
        stim = beat(a, 0, 1'b1, 1'b0); tick();
        stim = beat(b, 1, 1'b0, 1'b0); tick();
        stim = beat(c, 2, 1'b0, 1'b1); tick();
    endtask

    cellstruct vin [10];
    cellstruct vexp [10];
    cellstruct chain_q [$];
    cellstruct zero_c;
    int n_inj;
    logic [7:0] inj_data [2];

    initial begin
        zero_c = '0;
        // ---------------- reset state ----------------
        do_reset();
        check_value("reset_out", 32'(c0_out), 32'(zero_c));
        check_value("reset_cnt", 32'(c0_cnt), 32'd0);
        check_value("reset_ovf", 32'(c0_ovf), 32'd0);

        // ---------------- two vectors ----------------
        vin[0] = beat(4, 0, 1'b1, 1'b0); vin[1] = beat(5, 1, 1'b0, 1'b0); vin[2] = beat(6, 2, 1'b0, 1'b1);
        vin[3] = '0; vin[4] = '0;
        vin[5] = beat(2, 0, 1'b1, 1'b0); vin[6] = beat(3, 1, 1'b0, 1'b0); vin[7] = beat(4, 2, 1'b0, 1'b1);
        vin[8] = '0; vin[9] = '0;
        for (int k = 0; k < 10; k++) vexp[k] = vin[k];
        vexp[3] = res(17, 0);
        vexp[8] = res(11, 0);
        for (int k = 0; k < 10; k++) begin
            stim = vin[k];
            tick();
            check_value($sformatf("two_vec_k%0d", k), 32'(c0_out), 32'(vexp[k]));
            if (k == 2) check_value("two_vec_cnt_push", 32'(c0_cnt), 32'd1);
            if (k == 3) check_value("two_vec_cnt_pop", 32'(c0_cnt), 32'd0);
        end

        // ---------------- three-cell chain ----------------
        do_reset();
        chain_q.delete();
        stim = beat(4, 0, 1'b1, 1'b0); tick();
        stim = beat(5, 1, 1'b0, 1'b0); tick();
        stim = beat(6, 2, 1'b0, 1'b1); tick();
        stim = '0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (c2_out.isValid && c2_out.isResult) chain_q.push_back(c2_out);
        end
        check_value("chain_count", 32'(chain_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check_value($sformatf("chain_res%0d", i),
                        (i < chain_q.size()) ? 32'(chain_q[i]) : 32'hFFFF_FFFF,
                        32'(res(17 + 15 * i, i)));
        end
        check_value("chain_ovf", 32'({c0_ovf, c1_ovf, c2_ovf}), 32'd0);
        check_value("chain_pending", 32'({c0_cnt, c1_cnt, c2_cnt}), 32'd0);

        // ---------------- saturation and ReLU ----------------
        do_reset();
        send_vec(127, 127, 127);
        stim = '0; tick();
        check_value("sat_pos", 32'(s127_out), 32'(res(127, 3)));
        check_value("sat_neg", 32'(sn_out), 32'(res(-128, 4)));
        check_value("sat_relu_neg", 32'(sr_out), 32'(res(0, 5)));
        send_vec(5, 5, 5);
        stim = '0; tick();
        check_value("sat_pos_1905", 32'(s127_out), 32'(res(127, 3)));
        check_value("none_m15", 32'(sn_out), 32'(res(-15, 4)));
        check_value("relu_m15", 32'(sr_out), 32'(res(0, 5)));
        check_value("sat_pending", 32'({s127_cnt, sn_cnt, sr_cnt}), 32'd0);
        check_value("sat_ovf", 32'({s127_ovf, sn_ovf, sr_ovf}), 32'd0);

        // ---------------- FIFO overflow (depth 2) ----------------
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            stim = beat(k, 1, 1'b1, 1'b1);
            tick();
            if (k == 1) check_value("ovf_cnt1", 32'(ov_cnt), 32'd1);
            if (k == 2) check_value("ovf_not_yet", 32'(ov_ovf), 32'd0);
        end
        check_value("ovf_cnt_full", 32'(ov_cnt), 32'd2);
        check_value("ovf_flag", 32'(ov_ovf), 32'd1);
        stim = '0;
        n_inj = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (ov_out.isValid && ov_out.isResult) begin
                if (n_inj < 2) inj_data[n_inj] = ov_out.data;
                n_inj++;
            end
        end
        check_value("ovf_injected", 32'(n_inj), 32'd2);
        check_value("ovf_first", 32'(inj_data[0]), 32'd1);
        check_value("ovf_second", 32'(inj_data[1]), 32'd2);
        check_value("ovf_cnt_drain", 32'(ov_cnt), 32'd0);
        check_value("ovf_sticky", 32'(ov_ovf), 32'd1);

        // ---------------- result_fifo: push+pop while full ----------------
        do_reset();
        f_push = 1'b1; f_din = 8'd11; tick();
        check_value("fifo_cnt1", 32'(f_count), 32'd1);
        f_din = 8'd22; tick();
        check_value("fifo_full", 32'({f_full, f_count}), 32'b110);
        check_value("fifo_head11", 32'(f_dout), 32'd11);
        f_din = 8'd33; f_pop = 1'b1; tick();
        check_value("fifo_pp_cnt", 32'(f_count), 32'd2);
        check_value("fifo_pp_head", 32'(f_dout), 32'd22);
        f_din = 8'd44; f_pop = 1'b0; tick();
        check_value("fifo_drop_cnt", 32'(f_count), 32'd2);
        f_push = 1'b0; f_pop = 1'b1; tick();
        check_value("fifo_head33", 32'(f_dout), 32'd33);
        tick();
        check_value("fifo_empty", 32'({f_empty, f_count}), 32'b100);
        f_pop = 1'b0;

        // ---------------- runtime weights and reset ----------------
        do_reset();
        stim = beat(4, 0, 1'b1, 1'b0);
        weightWrEn = 1'b1; weightWrIndex = 8'd0; weightWrData = 8'sd10;
        tick();
        weightWrEn = 1'b0;
        stim = beat(5, 1, 1'b0, 1'b0); tick();
        stim = beat(6, 2, 1'b0, 1'b1); tick();
        stim = '0; tick();
        check_value("wr_old_weight", 32'(c0_out), 32'(res(17, 0)));
        stim = beat(4, 0, 1'b1, 1'b0);
        weightWrEn = 1'b1; weightWrIndex = 8'd3; weightWrData = 8'sd99;
        tick();
        weightWrEn = 1'b0;
        stim = beat(5, 1, 1'b0, 1'b0); tick();
        stim = beat(6, 2, 1'b0, 1'b1); tick();
        stim = '0; tick();
        check_value("wr_new_weight", 32'(c0_out), 32'(res(57, 0)));
        stim = beat(4, 0, 1'b1, 1'b0); tick();
        stim = beat(5, 1, 1'b0, 1'b0); tick();
        reset = 1'b1;
        stim = beat(6, 2, 1'b0, 1'b1);
        weightWrEn = 1'b1; weightWrIndex = 8'd1; weightWrData = 8'sd50;
        tick();
        check_value("rst_mid_out", 32'(c0_out), 32'(zero_c));
        check_value("rst_mid_cnt", 32'(c0_cnt), 32'd0);
        tick();
        check_value("rst_mid_out2", 32'(c0_out), 32'(zero_c));
        reset = 1'b0; weightWrEn = 1'b0; stim = '0;
        tick();
        check_value("rst_no_result", 32'(c0_out), 32'(zero_c));
        tick();
        check_value("rst_no_result2", 32'({c0_out.isValid, c0_cnt, c0_ovf}), 32'd0);
        send_vec(4, 5, 6);
        stim = '0; tick();
        check_value("rst_weights_restored", 32'(c0_out), 32'(res(17, 0)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stream_mac_cell.md
# stream_mac_cell

Parametrised successor to the single-neuron computation cell. It accumulates a weighted dot product over framed input vectors on the cell stream and passes every input beat downstream unchanged. Each finished result goes through a signed shift, saturation and an optional ReLU, then waits in a small FIFO until an idle stream slot lets it be injected. Cells are chained back-to-back to form a layer; weights can be rewritten at runtime.

## Interface
Parameters:
- INPUT_VECTOR_SIZE, 3: beats per vector; size of the weight table.
- WEIGHTS_INIT, all 0: array of INPUT_VECTOR_SIZE signed DATA_WIDTH values loaded on reset.
- CELL_ID, 0: placed in wIndex of injected results.
- ACTIVATION, ACT_NONE: ACT_NONE or ACT_RELU.
- OUT_SHIFT, 0: arithmetic right shift applied to the accumulator before saturation.
- RESULT_FIFO_DEPTH, 4: number of pending results held; must be at least 1.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- streamIn  in  cellstruct  upstream beat.
- streamOut  out  cellstruct  registered downstream beat.
- weightWrEn  in  1  weight write strobe.
- weightWrIndex  in  WINDEX_WIDTH  weight slot to write.
- weightWrData  in  DATA_WIDTH  signed weight value.
- overflow  out  1  sticky flag: a result was dropped because the FIFO was full.
- pendingCount  out  clog2(RESULT_FIFO_DEPTH+1)  current FIFO occupancy.

## Operation
- Fields of cellstruct: data, isValid, isFirst, isLast, isResult, wIndex. Data is signed two's complement.
- **Accumulate.** A beat is accumulated when isValid=1 and isResult=0.
  - product = data × weight[wIndex], signed.
  - If wIndex ≥ INPUT_VECTOR_SIZE, the product is 0.
  - isFirst=1 replaces the accumulator with the product; otherwise the product is added.
  - ACC_WIDTH = 2·DATA_WIDTH + clog2(INPUT_VECTOR_SIZE) + 1, so the accumulator never wraps.
- **Finish.**
  - On a beat with isLast=1, the final sum is acc + product; when isFirst=1 on the same beat, it is the product alone.
  - The final sum is shifted right by OUT_SHIFT, saturated to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1], and then ReLU (negative → 0) is applied if enabled.
  - The value is pushed into the FIFO on that same edge.
  - If the FIFO is full, the value is dropped and overflow is set.
  - A beat with isLast=1 and no prior isFirst uses whatever the accumulator holds.
- **Output selection**, each edge:
  - streamIn.isValid=1: streamOut takes streamIn verbatim. This applies to upstream results (isResult=1) too, which are never accumulated.
  - Otherwise, if the FIFO is not empty: streamOut = {data=head, isValid=1, isResult=1, isFirst=0, isLast=0, wIndex=CELL_ID}, and the FIFO is popped.
  - Otherwise: streamOut.isValid=0 and every other field is 0.
- **Simultaneous push and pop.** Both happen in one edge. Occupancy is unchanged, and a full FIFO does not drop the pushed value.
- **Weight write.** Takes effect at the edge. A beat in the same cycle uses the old weight. Indices ≥ INPUT_VECTOR_SIZE are ignored.
- **Reset.**
  - Accumulator, FIFO and overflow are cleared.
  - Weights reload from WEIGHTS_INIT.
  - streamOut is all zero; pendingCount = 0.
  - Reset mid-vector abandons that vector; its isLast produces no result.
  - Reset dominates weight writes and input beats in the same cycle.

## Timing
- Pass-through latency is 1 cycle.
- A result pushed at edge N is injected at the first edge M > N with streamIn.isValid=0. It appears on streamOut after edge M.
- The earliest possible injection is N+1.
- Results leave in FIFO order.
- Full throughput: one input beat per cycle; there is no backpressure. Upstream must leave idle slots for injection.
- overflow and pendingCount are registered and updated at the same edge as the push/pop that changes them.

## Structure
- cell_package holds:
  - DATA_WIDTH (8) and WINDEX_WIDTH (8);
  - cellstruct;
  - the activation enum (ACT_NONE, ACT_RELU);
  - a saturate function.
- Sub-module result_fifo: synchronous circular-buffer FIFO with parameters WIDTH and DEPTH, plus push, pop, full, empty and count. Push and pop in the same cycle are legal when full.
- The weight table is a register array held in stream_mac_cell.

## Test plan
- **Two vectors.** Weights {0,1,2}. Send {4,5,6} framed first/last with wIndex 0,1,2, then 2 idle, then {2,3,4}, then 2 idle.
  - Required: a result of 17 injected on the first idle slot, and 11 on the idle slot after the second vector.
  - All data beats appear 1 cycle later, unchanged.
- **Three-cell chain.** Weights {0,1,2}, {1,2,3}, {2,3,4}, input {4,5,6}, with 4 idle slots after.
  - Required: results 17, 32, 47 arrive at the chain output in that order, tagged with CELL_IDs 0, 1, 2.
- **Saturation and ReLU.**
  - Weights {127,127,127}, data {127,127,127}, OUT_SHIFT=0 → 127.
  - Weights {−1,−1,−1}, data {5,5,5}: ACT_NONE → −15; ACT_RELU → 0.
- **FIFO overflow.** RESULT_FIFO_DEPTH=2. Send five 1-beat vectors back-to-back with no idle slots.
  - Required: pendingCount reaches 2, overflow=1, and exactly 2 results are injected later.
  - Separately, with the FIFO full, a push in the same cycle as a pop is not dropped.
- **Runtime weights and reset.**
  - A weight write in the same cycle as the data beat uses the old weight; the next vector uses the new weight.
  - Assert reset after 2 beats of a vector: no result, outputs zero, and weights restored to WEIGHTS_INIT.
